inst_encoder: RTL

//  Inverse of the instruction decoder. Accepts decoded instruction fields from the host/loader over a valid/ready handshake.

---
 rtl/inst_encoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction fields into 32-bit words in the
// decoder's field format and writes them sequentially into instruction memory,
// starting at BASE_ADDR. Used for program load and self-test images.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   start_i                 begin a load session (honoured in idle only)
//   valid_i / ready_o       field tuple handshake
//   last_i                  tuple is the final word of the session
//   alu_i .. ram_addr_i     decoded instruction fields
//   wr_en_o/addr_o/data_o   instruction memory write port (addr/data registered)
//   busy_o                  session in progress
//   done_o                  one-cycle pulse at session end
//   count_o                 words written this session
//   err_o                   address space exhausted before last_i
module inst_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned END_ADDR  = 255,
  // Opcode/flag encodings shared with the decoder.
  parameter logic [7:0]  MOVEIN    = 8'h0C,
  parameter logic        IMM_YES   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              last_i,
  input  logic [7:0]        alu_i,
  input  logic [1:0]        pc_i,
  input  logic [1:0]        reg_i,
  input  logic              imm_i,
  input  logic              mem_i,
  input  logic [4:0]        reg_addr_1_i,
  input  logic [4:0]        reg_addr_2_i,
  input  logic [4:0]        reg_addr_3_i,
  input  logic [7:0]        imm_data_i,
  input  logic [15:0]       ram_addr_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   count_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] EndAddr  = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                last_q, last_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic [31:0]         packed_word;

  // Field packing; unused bits stay zero. Opcode legality is not checked.
  always_comb begin
    packed_word        = '0;
    packed_word[31:18] = {alu_i, pc_i, reg_i, imm_i, mem_i};
    if (imm_i != IMM_YES) begin
      packed_word[17:13] = reg_addr_1_i;
      packed_word[12:8]  = reg_addr_2_i;
      packed_word[7:3]   = reg_addr_3_i;
    end else if (alu_i == MOVEIN) begin
      packed_word[17:2] = ram_addr_i;
    end else begin
      packed_word[17:10] = imm_data_i;
      packed_word[9:5]   = reg_addr_1_i;
      packed_word[4:0]   = reg_addr_2_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    count_d   = count_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLoad;
          addr_d  = BaseAddr;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        // ready_o is high throughout this state, so valid_i alone is an accept.
        if (valid_i) begin
          wr_data_d = packed_word;
          wr_addr_d = addr_q;
          last_d    = last_i;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        count_d = count_q + CountOne;
        if (last_q) begin
          state_d = StDone;
        end else if (addr_q == EndAddr) begin
          // Never wrap: running out of space ends the session with an error.
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StLoad;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      addr_q    <= BaseAddr;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      last_q    <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  // Strobes decode straight from the state register, so reset clears them at once.
  assign ready_o   = (state_q == StLoad);
  assign wr_en_o   = (state_q == StWrite);
  assign done_o    = (state_q == StDone);
  assign busy_o    = (state_q != StIdle);
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign count_o   = count_q;
  assign err_o     = err_q;

endmodule
